// File: rtl/bp_pkg.sv
// bp_pkg: shared types and default sizes for the branch-prediction controller
package bp_pkg;
  localparam int BP_HISTORY_WIDTH = 3;
  localparam int BP_PC_WIDTH = 10;
  localparam int BP_DEPTH = 4;
  typedef enum logic {RUN, FLUSH} bp_state_t;
  typedef struct packed {
    logic [BP_HISTORY_WIDTH-1:0] idx;
    logic pred;
  } bp_entry_t;
endpackage

// File: rtl/bp_inflight_fifo.sv
// bp_inflight_fifo: in-order queue of in-flight predictions, clear beats push
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  bp_entry_t                  din,
  output bp_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  bp_entry_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + PW'(do_push);
      rp <= rp + PW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/bp_ctrl.sv
// bp_ctrl: branch prediction controller with in-flight tracking, table update and mispredict flush
module bp_ctrl
  import bp_pkg::*;
#(
  parameter int HISTORY_WIDTH = BP_HISTORY_WIDTH,
  parameter int PC_WIDTH = BP_PC_WIDTH,
  parameter int DEPTH = BP_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic [PC_WIDTH-1:0]        fetch_pc,
  output logic                       fetch_ready,
  output logic                       pred_taken,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  output logic                       mispredict,
  output logic                       resolve_err,
  output logic [$clog2(DEPTH+1)-1:0] inflight_count,
  output logic [HISTORY_WIDTH-1:0]   tbl_addr,
  input  logic [1:0]                 tbl_rec,
  output logic [HISTORY_WIDTH-1:0]   tbl_wr_addr,
  output logic                       tbl_update,
  output logic                       tbl_taken
);
  bp_state_t state, state_nxt;
  bp_entry_t head;
  logic full, empty, push, acc, mis;
  logic unused;
  assign unused = ^{fetch_pc[PC_WIDTH-1:HISTORY_WIDTH], tbl_rec[0]};
  assign tbl_addr = fetch_pc[HISTORY_WIDTH-1:0];
  assign pred_taken = tbl_rec[1];
  assign fetch_ready = !rst && state == RUN && !full;
  assign push = fetch_valid && fetch_ready;
  assign acc = resolve_valid && !empty;
  assign mis = acc && (resolve_taken != head.pred);
  bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (acc),
    .clear (mis),
    .din   ('{idx: tbl_addr, pred: tbl_rec[1]}),
    .head  (head),
    .count (inflight_count),
    .full  (full),
    .empty (empty)
  );
  always_comb begin
    state_nxt = RUN;
    state_nxt = mis ? FLUSH : state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      tbl_update <= 1'b0;
      tbl_wr_addr <= '0;
      tbl_taken <= 1'b0;
      mispredict <= 1'b0;
      resolve_err <= 1'b0;
    end else begin
      state <= state_nxt;
      tbl_update <= acc;
      tbl_wr_addr <= acc ? head.idx : tbl_wr_addr;
      tbl_taken <= acc ? resolve_taken : tbl_taken;
      mispredict <= mis;
      resolve_err <= resolve_err || (resolve_valid && empty);
    end
  end
endmodule

// File: tb/tb_bp_ctrl.sv
// tb_bp_ctrl: directed checks of bp_ctrl against a behavioural prediction table
module tb_bp_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fetch_valid = 1'b0;
  logic [9:0] fetch_pc = '0;
  logic fetch_ready, pred_taken, mispredict, resolve_err, tbl_update, tbl_taken;
  logic resolve_valid = 1'b0;
  logic resolve_taken = 1'b0;
  logic [2:0] inflight_count, tbl_addr, tbl_wr_addr;
  logic [1:0] tbl_rec;
  logic [1:0] tbl [8];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  bp_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_ready    (fetch_ready),
    .pred_taken     (pred_taken),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .mispredict     (mispredict),
    .resolve_err    (resolve_err),
    .inflight_count (inflight_count),
    .tbl_addr       (tbl_addr),
    .tbl_rec        (tbl_rec),
    .tbl_wr_addr    (tbl_wr_addr),
    .tbl_update     (tbl_update),
    .tbl_taken      (tbl_taken)
  );
  assign tbl_rec = tbl[tbl_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) tbl[i] <= 2'd0;
    end else if (tbl_update) begin
      if (tbl_taken && tbl[tbl_wr_addr] != 2'd3) tbl[tbl_wr_addr] <= tbl[tbl_wr_addr] + 2'd1;
      if (!tbl_taken && tbl[tbl_wr_addr] != 2'd0) tbl[tbl_wr_addr] <= tbl[tbl_wr_addr] - 2'd1;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    step();
    step();
    chk("rst_ready", 32'(fetch_ready), 0);
    chk("rst_count", 32'(inflight_count), 0);
    chk("rst_update", 32'(tbl_update), 0);
    chk("rst_mis", 32'(mispredict), 0);
    chk("rst_err", 32'(resolve_err), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(fetch_ready), 1);
    fetch_valid = 1'b1;
    fetch_pc = 10'h005;
    #1;
    chk("cold_addr", 32'(tbl_addr), 5);
    chk("cold_pred", 32'(pred_taken), 0);
    step();
    fetch_valid = 1'b0;
    chk("cold_count", 32'(inflight_count), 1);
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    step();
    resolve_valid = 1'b0;
    chk("cold_upd", 32'(tbl_update), 1);
    chk("cold_wa", 32'(tbl_wr_addr), 5);
    chk("cold_tk", 32'(tbl_taken), 1);
    chk("cold_mis", 32'(mispredict), 1);
    chk("cold_ready", 32'(fetch_ready), 0);
    chk("cold_cnt0", 32'(inflight_count), 0);
    step();
    chk("cold_ready2", 32'(fetch_ready), 1);
    chk("cold_mis2", 32'(mispredict), 0);
    chk("cold_pred_weak", 32'(pred_taken), 0);
    fetch_valid = 1'b1;
    step();
    fetch_valid = 1'b0;
    resolve_valid = 1'b1;
    step();
    resolve_valid = 1'b0;
    chk("train_mis", 32'(mispredict), 1);
    step();
    chk("train_pred", 32'(pred_taken), 1);
    fetch_valid = 1'b1;
    step();
    fetch_valid = 1'b0;
    resolve_valid = 1'b1;
    step();
    resolve_valid = 1'b0;
    chk("hit_mis", 32'(mispredict), 0);
    chk("hit_upd", 32'(tbl_update), 1);
    chk("hit_wa", 32'(tbl_wr_addr), 5);
    for (int i = 0; i < 4; i++) begin
      fetch_valid = 1'b1;
      fetch_pc = 10'h010 + 10'(i);
      step();
    end
    fetch_pc = 10'h014;
    #1;
    chk("full_count", 32'(inflight_count), 4);
    chk("full_ready", 32'(fetch_ready), 0);
    step();
    fetch_valid = 1'b0;
    chk("full_ignored", 32'(inflight_count), 4);
    resolve_valid = 1'b1;
    resolve_taken = 1'b0;
    step();
    resolve_valid = 1'b0;
    chk("full_pop_cnt", 32'(inflight_count), 3);
    chk("full_pop_wa", 32'(tbl_wr_addr), 0);
    chk("full_pop_mis", 32'(mispredict), 0);
    fetch_valid = 1'b1;
    fetch_pc = 10'h020;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    #1;
    chk("coll_ready", 32'(fetch_ready), 1);
    step();
    fetch_valid = 1'b0;
    resolve_valid = 1'b0;
    chk("coll_mis", 32'(mispredict), 1);
    chk("coll_cnt", 32'(inflight_count), 0);
    chk("coll_upd", 32'(tbl_update), 1);
    chk("coll_wa", 32'(tbl_wr_addr), 1);
    step();
    chk("coll_upd_once", 32'(tbl_update), 0);
    chk("coll_cnt2", 32'(inflight_count), 0);
    resolve_valid = 1'b1;
    step();
    resolve_valid = 1'b0;
    chk("empty_err", 32'(resolve_err), 1);
    chk("empty_upd", 32'(tbl_update), 0);
    chk("empty_mis", 32'(mispredict), 0);
    step();
    step();
    chk("empty_sticky", 32'(resolve_err), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("err_cleared", 32'(resolve_err), 0);
    resolve_taken = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      fetch_valid = k < 12;
      fetch_pc = 10'h008 + 10'(k);
      resolve_valid = k > 0;
      step();
      if (k > 0) begin
        chk("wrap_wa", 32'(tbl_wr_addr), 32'((k - 1) % 8));
        chk("wrap_mis", 32'(mispredict), 0);
      end
    end
    fetch_valid = 1'b0;
    resolve_valid = 1'b0;
    chk("wrap_cnt", 32'(inflight_count), 0);
    fetch_valid = 1'b1;
    fetch_pc = 10'h001;
    step();
    fetch_pc = 10'h002;
    step();
    fetch_valid = 1'b0;
    chk("mid_cnt", 32'(inflight_count), 2);
    rst = 1'b1;
    resolve_valid = 1'b1;
    step();
    rst = 1'b0;
    resolve_valid = 1'b0;
    #1;
    chk("mid_cnt0", 32'(inflight_count), 0);
    chk("mid_upd", 32'(tbl_update), 0);
    chk("mid_ready", 32'(fetch_ready), 1);
    resolve_valid = 1'b1;
    step();
    resolve_valid = 1'b0;
    chk("mid_err", 32'(resolve_err), 1);
    chk("mid_upd2", 32'(tbl_update), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
